// File: rtl/reg_scoreboard_if.sv
// Issue/writeback bundle between the ID stage and its register-hazard scoreboard.
// Combinational stall/issue_fire back to the ID stage; registered status outputs.
// No backpressure on writebacks; stall is the only hold-off to the issuer.
interface reg_scoreboard_if #(
    parameter int REG_NUM    = 32,
    parameter int ADDR_W     = 5,
    parameter int READ_PORTS = 2,
    parameter int INFLIGHT_W = 8
);
    logic                         flush;
    logic                         issue_valid;
    logic [READ_PORTS-1:0]        rd_en;
    logic [READ_PORTS*ADDR_W-1:0] rd_addr;
    logic                         wr_en;
    logic [ADDR_W-1:0]            wr_addr;
    logic                         wb_valid;
    logic [ADDR_W-1:0]            wb_addr;
    logic                         stall;
    logic                         issue_fire;
    logic [REG_NUM-1:0]           busy_vec;
    logic [INFLIGHT_W-1:0]        inflight;
    logic                         underflow_err;

    modport master (
        output flush, issue_valid, rd_en, rd_addr, wr_en, wr_addr, wb_valid, wb_addr,
        input  stall, issue_fire, busy_vec, inflight, underflow_err
    );

    modport slave (
        input  flush, issue_valid, rd_en, rd_addr, wr_en, wr_addr, wb_valid, wb_addr,
        output stall, issue_fire, busy_vec, inflight, underflow_err
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register saturating pending-write counters; stalls ID on RAW hazard or counter saturation.
// stall/issue_fire are zero-latency combinational; counters/busy_vec/inflight update one edge later.
// Writebacks always accepted; stall holds the issuer. SCOREBOARD_BYPASS_EN: WB-cycle reads don't stall.
module reg_scoreboard #(
    parameter int REG_NUM     = 32,
    parameter int ADDR_W      = 5,
    parameter int READ_PORTS  = 2,
    parameter int MAX_PENDING = 3,
    parameter int INFLIGHT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    reg_scoreboard_if.slave  sb
);
    localparam int CNT_W      = $clog2(MAX_PENDING + 1);
    localparam int ADDR_SPACE = 2 ** ADDR_W;

    logic [CNT_W-1:0] cnt_q  [1:REG_NUM-1];
    // Full address-space view; r0 and out-of-range addresses read as count 0.
    logic [CNT_W-1:0] cnt_of [ADDR_SPACE];

    logic                  rd_busy;
    logic                  saturated;
    logic                  stall;
    logic                  fire;
    logic                  inc_any;
    logic                  dec_any;
    logic                  wb_err;
    logic [INFLIGHT_W-1:0] inflight_q;
    logic                  underflow_q;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (a != '0) && (32'(a) < 32'(REG_NUM));
    endfunction

    always_comb begin
        for (int i = 0; i < ADDR_SPACE; i++) begin
            cnt_of[i] = '0;
        end
        for (int r = 1; r < REG_NUM; r++) begin
            cnt_of[r] = cnt_q[r];
        end
    end

    always_comb begin
        rd_busy = 1'b0;
        for (int i = 0; i < READ_PORTS; i++) begin
            automatic logic [ADDR_W-1:0] a = sb.rd_addr[i*ADDR_W +: ADDR_W];
            automatic logic hit = sb.rd_en[i] && (cnt_of[a] != '0);
`ifdef SCOREBOARD_BYPASS_EN
            // Last pending write retiring this cycle is forwarded from WB.
            if (sb.wb_valid && (sb.wb_addr == a) && (cnt_of[a] == CNT_W'(1))) begin
                hit = 1'b0;
            end
`endif
            rd_busy = rd_busy | hit;
        end
    end

    assign saturated = sb.wr_en && (cnt_of[sb.wr_addr] == CNT_W'(MAX_PENDING))
                       && !(sb.wb_valid && (sb.wb_addr == sb.wr_addr));
    assign stall     = sb.issue_valid && (rd_busy || saturated);
    assign fire      = sb.issue_valid && !stall && !sb.flush;

    assign inc_any = fire && sb.wr_en && addr_ok(sb.wr_addr);
    assign dec_any = sb.wb_valid && (cnt_of[sb.wb_addr] != '0);
    assign wb_err  = sb.wb_valid && addr_ok(sb.wb_addr) && (cnt_of[sb.wb_addr] == '0) && !sb.flush;

    for (genvar r = 1; r < REG_NUM; r++) begin : g_cnt
        logic inc;
        logic dec;
        assign inc = fire && sb.wr_en && (sb.wr_addr == ADDR_W'(r));
        assign dec = sb.wb_valid && (sb.wb_addr == ADDR_W'(r)) && (cnt_q[r] != '0);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q[r] <= '0;
            end else if (sb.flush) begin
                cnt_q[r] <= '0;
            end else if (inc && !dec) begin
                cnt_q[r] <= cnt_q[r] + CNT_W'(1);
            end else if (dec && !inc) begin
                cnt_q[r] <= cnt_q[r] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= '0;
        end else if (sb.flush) begin
            inflight_q <= '0;
        end else if (inc_any && !dec_any) begin
            inflight_q <= inflight_q + INFLIGHT_W'(1);
        end else if (dec_any && !inc_any) begin
            inflight_q <= inflight_q - INFLIGHT_W'(1);
        end
    end

    // Sticky until reset; flush deliberately leaves it set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underflow_q <= 1'b0;
        end else if (wb_err) begin
            underflow_q <= 1'b1;
        end
    end

    always_comb begin
        sb.busy_vec = '0;
        for (int r = 1; r < REG_NUM; r++) begin
            sb.busy_vec[r] = (cnt_q[r] != '0);
        end
    end

    assign sb.stall         = stall;
    assign sb.issue_fire    = fire;
    assign sb.inflight      = inflight_q;
    assign sb.underflow_err = underflow_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed vectors plus a per-cycle reference model.
module tb_reg_scoreboard;
    localparam int REG_NUM     = 32;
    localparam int ADDR_W      = 5;
    localparam int READ_PORTS  = 2;
    localparam int MAX_PENDING = 3;
    localparam int INFLIGHT_W  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    reg_scoreboard_if #(.REG_NUM(REG_NUM), .ADDR_W(ADDR_W), .READ_PORTS(READ_PORTS),
                        .INFLIGHT_W(INFLIGHT_W)) sb_if ();

    reg_scoreboard #(.REG_NUM(REG_NUM), .ADDR_W(ADDR_W), .READ_PORTS(READ_PORTS),
                     .MAX_PENDING(MAX_PENDING), .INFLIGHT_W(INFLIGHT_W)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: pending-write count per architectural register.
    int m_cnt [REG_NUM];
    bit m_uf;

    function automatic int norm(input logic [ADDR_W-1:0] a);
        return (int'(a) < REG_NUM) ? int'(a) : 0;
    endfunction

    function automatic bit m_read_busy(input logic [ADDR_W-1:0] a);
        int r = norm(a);
        if (r == 0 || m_cnt[r] == 0) return 1'b0;
`ifdef SCOREBOARD_BYPASS_EN
        if (sb_if.wb_valid && norm(sb_if.wb_addr) == r && m_cnt[r] == 1) return 1'b0;
`endif
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        bit e_stall, e_fire;
        int w, b, e_infl;
        logic [REG_NUM-1:0] e_busy;
        if (rst) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_uf = 1'b0;
        end
        e_stall = 1'b0;
        if (sb_if.issue_valid) begin
            for (int i = 0; i < READ_PORTS; i++)
                if (sb_if.rd_en[i] && m_read_busy(sb_if.rd_addr[i*ADDR_W +: ADDR_W])) e_stall = 1'b1;
            w = norm(sb_if.wr_addr);
            if (sb_if.wr_en && w != 0 && m_cnt[w] == MAX_PENDING
                && !(sb_if.wb_valid && norm(sb_if.wb_addr) == w)) e_stall = 1'b1;
        end
        e_fire = sb_if.issue_valid && !e_stall && !sb_if.flush;
        e_infl = 0;
        e_busy = '0;
        for (int r = 1; r < REG_NUM; r++) begin
            e_infl += m_cnt[r];
            e_busy[r] = (m_cnt[r] > 0);
        end
        chk("stall", 64'(sb_if.stall), 64'(e_stall));
        chk("issue_fire", 64'(sb_if.issue_fire), 64'(e_fire));
        chk("busy_vec", 64'(sb_if.busy_vec), 64'(e_busy));
        chk("inflight", 64'(sb_if.inflight), 64'(e_infl));
        chk("underflow_err", 64'(sb_if.underflow_err), 64'(m_uf));
        if (!rst) begin
            if (sb_if.flush) begin
                foreach (m_cnt[i]) m_cnt[i] = 0;
            end else begin
                bit do_dec;
                w = norm(sb_if.wr_addr);
                b = norm(sb_if.wb_addr);
                do_dec = sb_if.wb_valid && b != 0 && m_cnt[b] > 0;
                if (sb_if.wb_valid && b != 0 && m_cnt[b] == 0) m_uf = 1'b1;
                if (e_fire && sb_if.wr_en && w != 0) m_cnt[w]++;
                if (do_dec) m_cnt[b]--;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        sb_if.flush = 0; sb_if.issue_valid = 0; sb_if.rd_en = '0; sb_if.rd_addr = '0;
        sb_if.wr_en = 0; sb_if.wr_addr = '0; sb_if.wb_valid = 0; sb_if.wb_addr = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_busy_vec", 64'(sb_if.busy_vec), 64'd0);
        chk("rst_inflight", 64'(sb_if.inflight), 64'd0);
        chk("rst_underflow", 64'(sb_if.underflow_err), 64'd0);

        // Write r5, then dependent read of r5.
        sb_if.issue_valid = 1; sb_if.wr_en = 1; sb_if.wr_addr = 5'd5;
        #1 chk("w5_fire", 64'(sb_if.issue_fire), 64'd1);
        step();
        sb_if.wr_en = 0; sb_if.rd_en = 2'b01; sb_if.rd_addr = {5'd0, 5'd5};
        #1;
        chk("raw_stall", 64'(sb_if.stall), 64'd1);
        chk("busy5", 64'(sb_if.busy_vec[5]), 64'd1);
        chk("inflight1", 64'(sb_if.inflight), 64'd1);
        step();
        sb_if.wb_valid = 1; sb_if.wb_addr = 5'd5;
        #1;
`ifdef SCOREBOARD_BYPASS_EN
        chk("wb_cycle_stall", 64'(sb_if.stall), 64'd0);
`else
        chk("wb_cycle_stall", 64'(sb_if.stall), 64'd1);
`endif
        step();
        sb_if.wb_valid = 0;
        #1;
        chk("after_wb_stall", 64'(sb_if.stall), 64'd0);
        chk("after_wb_inflight", 64'(sb_if.inflight), 64'd0);

        // Saturate r7.
        sb_if.rd_en = '0; sb_if.wr_en = 1; sb_if.wr_addr = 5'd7;
        repeat (3) step();
        #1;
        chk("sat_stall", 64'(sb_if.stall), 64'd1);
        chk("sat_inflight", 64'(sb_if.inflight), 64'd3);
        sb_if.wb_valid = 1; sb_if.wb_addr = 5'd7;
        #1 chk("sat_wb_stall", 64'(sb_if.stall), 64'd0);
        step();
        sb_if.issue_valid = 0; sb_if.wr_en = 0;
        #1;
        chk("sat_keep3", 64'(sb_if.inflight), 64'd3);
        chk("busy7", 64'(sb_if.busy_vec[7]), 64'd1);
        repeat (3) step();
        sb_if.wb_valid = 0;
        #1 chk("drain7", 64'(sb_if.inflight), 64'd0);

        // Register 0 never tracked.
        sb_if.issue_valid = 1; sb_if.wr_en = 1; sb_if.wr_addr = '0;
        sb_if.rd_en = 2'b11; sb_if.rd_addr = '0;
        #1 chk("r0_stall", 64'(sb_if.stall), 64'd0);
        step();
        sb_if.issue_valid = 0; sb_if.wr_en = 0; sb_if.rd_en = '0;
        #1;
        chk("r0_busy", 64'(sb_if.busy_vec[0]), 64'd0);
        chk("r0_inflight", 64'(sb_if.inflight), 64'd0);

        // Underflow on idle r9, sticky through flush.
        sb_if.wb_valid = 1; sb_if.wb_addr = 5'd9;
        step();
        sb_if.wb_valid = 0;
        #1;
        chk("uf_set", 64'(sb_if.underflow_err), 64'd1);
        chk("uf_inflight", 64'(sb_if.inflight), 64'd0);
        sb_if.flush = 1;
        step();
        sb_if.flush = 0;
        #1 chk("uf_after_flush", 64'(sb_if.underflow_err), 64'd1);

        // Fill r3..r5 then flush with a concurrent issue to r6.
        sb_if.issue_valid = 1; sb_if.wr_en = 1; sb_if.wr_addr = 5'd3;
        step();
        sb_if.wr_addr = 5'd4;
        step();
        sb_if.wr_addr = 5'd5;
        step();
        #1 chk("fill_inflight", 64'(sb_if.inflight), 64'd3);
        sb_if.flush = 1; sb_if.wr_addr = 5'd6;
        #1 chk("flush_fire", 64'(sb_if.issue_fire), 64'd0);
        step();
        sb_if.flush = 0; sb_if.issue_valid = 0; sb_if.wr_en = 0;
        #1;
        chk("flush_busy", 64'(sb_if.busy_vec), 64'd0);
        chk("flush_inflight", 64'(sb_if.inflight), 64'd0);

        // Asynchronous reset in the middle of a stall.
        sb_if.issue_valid = 1; sb_if.wr_en = 1; sb_if.wr_addr = 5'd3;
        step();
        sb_if.wr_en = 0; sb_if.rd_en = 2'b10; sb_if.rd_addr = {5'd3, 5'd0};
        #1 chk("pre_rst_stall", 64'(sb_if.stall), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_busy", 64'(sb_if.busy_vec), 64'd0);
        chk("arst_inflight", 64'(sb_if.inflight), 64'd0);
        chk("arst_underflow", 64'(sb_if.underflow_err), 64'd0);
        chk("arst_stall", 64'(sb_if.stall), 64'd0);
        step();
        rst = 1'b0;
        step();
        sb_if.issue_valid = 0; sb_if.rd_en = '0;
        step();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
